// File: rtl/mdu_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// master = issuing stage, slave = mdu_iter.
interface mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_opt;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        output req_valid, req_opt, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
    modport slave (
        input  req_valid, req_opt, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit, one step per clock, one op in flight.
// Define MDU_SIGNED_EN to build the signed MULH/DIV/REM opcodes.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic  clk,
    input logic  rst_n,
    input logic  flush,
    mdu_if.slave mdu
);
    localparam int CW = $clog2(XLEN);
    localparam logic [3:0] OP_MUL = 4'h0, OP_MULHU = 4'h1, OP_DIVU = 4'h2, OP_REMU = 4'h3;
    localparam logic [3:0] OP_MULH = 4'h4, OP_DIV = 4'h5, OP_REM = 4'h6;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, acc_step;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [TAG_W-1:0]    tag_q, tag_d, rsp_tag_q, rsp_tag_d;
    logic [XLEN-1:0]     rsp_data_q, rsp_data_d, done_res;
    logic                rsp_err_q, rsp_err_d;
    logic                accept, req_mul, req_div, op_is_mul;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       mul_sum, div_top, div_diff;

    assign accept    = (state_q == IDLE) && mdu.req_valid && !flush;
    assign op_is_mul = op_q inside {OP_MUL, OP_MULHU, OP_MULH};

`ifdef MDU_SIGNED_EN
    localparam logic [XLEN-1:0]   ONE_X  = XLEN'(1);
    localparam logic [2*XLEN-1:0] ONE_2X = (2*XLEN)'(1);
    logic              sgn_op, a_neg, b_neg, neg_q, neg_d;
    logic [2*XLEN-1:0] prod_fix;

    assign req_mul  = mdu.req_opt inside {OP_MUL, OP_MULHU, OP_MULH};
    assign req_div  = mdu.req_opt inside {OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    assign sgn_op   = mdu.req_opt inside {OP_MULH, OP_DIV, OP_REM};
    assign a_neg    = sgn_op & mdu.req_a[XLEN-1];
    assign b_neg    = sgn_op & mdu.req_b[XLEN-1];
    assign a_mag    = a_neg ? (~mdu.req_a + ONE_X) : mdu.req_a;
    assign b_mag    = b_neg ? (~mdu.req_b + ONE_X) : mdu.req_b;
    // Remainder follows the dividend's sign; product and quotient the XOR.
    assign neg_d    = accept ? ((mdu.req_opt == OP_REM) ? a_neg : (a_neg ^ b_neg)) : neg_q;
    assign prod_fix = neg_q ? (~acc_step + ONE_2X) : acc_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    assign req_mul = mdu.req_opt inside {OP_MUL, OP_MULHU};
    assign req_div = mdu.req_opt inside {OP_DIVU, OP_REMU};
    assign a_mag   = mdu.req_a;
    assign b_mag   = mdu.req_b;
`endif

    // Multiply: acc = {partial, multiplier}, shifted right once per step.
    // Divide: acc = {remainder, quotient}, shifted left once per step.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign div_top  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_top - {1'b0, opnd_q};
    assign acc_step = op_is_mul ? {mul_sum, acc_q[XLEN-1:1]}
                    : div_diff[XLEN] ? {div_top[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    always_comb begin
        done_res = '0;
        case (op_q)
            OP_MUL:   done_res = acc_step[XLEN-1:0];
            OP_MULHU: done_res = acc_step[2*XLEN-1:XLEN];
            OP_DIVU:  done_res = acc_step[XLEN-1:0];
            OP_REMU:  done_res = acc_step[2*XLEN-1:XLEN];
`ifdef MDU_SIGNED_EN
            OP_MULH:  done_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV:   done_res = neg_q ? (~acc_step[XLEN-1:0] + ONE_X) : acc_step[XLEN-1:0];
            OP_REM:   done_res = neg_q ? (~acc_step[2*XLEN-1:XLEN] + ONE_X)
                                       : acc_step[2*XLEN-1:XLEN];
`endif
            default:  done_res = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d  = mdu.req_opt;
                tag_d = mdu.req_tag;
                if (!(req_mul || req_div)) begin
                    state_d    = DONE;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    rsp_tag_d  = mdu.req_tag;
                end else if (req_div && mdu.req_b == '0) begin
                    state_d    = DONE;
                    rsp_data_d = (mdu.req_opt inside {OP_DIVU, OP_DIV}) ? '1 : mdu.req_a;
                    rsp_err_d  = 1'b0;
                    rsp_tag_d  = mdu.req_tag;
                end else begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, req_mul ? b_mag : a_mag};
                    opnd_d  = req_mul ? a_mag : b_mag;
                end
            end
            BUSY: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN-1)) begin
                    state_d    = DONE;
                    rsp_data_d = done_res;
                    rsp_err_d  = 1'b0;
                    rsp_tag_d  = tag_q;
                end
            end
            DONE: if (mdu.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign mdu.req_ready = (state_q == IDLE) && !flush;
    assign mdu.rsp_valid = (state_q == DONE);
    assign mdu.rsp_data  = rsp_data_q;
    assign mdu.rsp_tag   = rsp_tag_q;
    assign mdu.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed vector table, handshake/flush/reset sequences,
// and random operations against an arithmetic reference model.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef MDU_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    mdu_if #(.XLEN(32), .TAG_W(5)) bus ();
    mdu_iter #(.XLEN(32), .TAG_W(5)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .mdu(bus.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  opt;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    vec_t vecs[20];
    int   nvec = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] opt, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] d, input logic e, input int lat);
        vecs[nvec] = '{opt, a, b, tag, d, e, lat};
        nvec++;
    endtask

    // Reference: results straight from integer arithmetic and the opcode rules.
    function automatic void model(input logic [3:0] opt, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic e, output int lat);
        logic [63:0] p;
        longint      sp;
        int          sa, sb, sq;
        sa = a; sb = b;
        d = '0; e = 1'b0; lat = 33;
        case (opt)
            4'h0: begin p = 64'(a) * 64'(b); d = p[31:0]; end
            4'h1: begin p = 64'(a) * 64'(b); d = p[63:32]; end
            4'h2: if (b == 0) begin d = 32'hFFFF_FFFF; lat = 1; end else d = a / b;
            4'h3: if (b == 0) begin d = a; lat = 1; end else d = a % b;
            4'h4: if (!SGN) begin e = 1'b1; lat = 1; end
                  else begin sp = longint'(sa) * longint'(sb); p = sp; d = p[63:32]; end
            4'h5: if (!SGN) begin e = 1'b1; lat = 1; end
                  else if (b == 0) begin d = 32'hFFFF_FFFF; lat = 1; end
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) d = a;
                  else begin sq = sa / sb; d = sq; end
            4'h6: if (!SGN) begin e = 1'b1; lat = 1; end
                  else if (b == 0) begin d = a; lat = 1; end
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) d = '0;
                  else begin sq = sa % sb; d = sq; end
            default: begin e = 1'b1; lat = 1; end
        endcase
    endfunction

    // One full transaction; lat counts edges from the accept edge (inclusive).
    task automatic run_op(input logic [3:0] opt, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] d, output logic [4:0] t,
                          output logic e, output int lat);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opt = opt; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
        while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        d = bus.rsp_data; t = bus.rsp_tag; e = bus.rsp_err;
        @(negedge clk); bus.rsp_ready = 1'b1;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;
    endtask

    task automatic watch_quiet(input string nm, input int cycles);
        int seen = 0;
        repeat (cycles) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
        chk(nm, seen, 0);
    endtask

    initial begin
        logic [31:0] d, ed, held_d;
        logic [4:0]  t, held_t, tg;
        logic [3:0]  op;
        logic [31:0] ra, rb;
        logic        e, ee;
        int          lat, el, r;
        logic [3:0]  ops[9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};

        bus.req_valid = 1'b0; bus.req_opt = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_tag = '0; bus.rsp_ready = 1'b0;

        add(4'h0, 32'd12345, 32'd6789, 5'd7, 32'd83810205, 1'b0, 33);
        add(4'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1'b0, 33);
        add(4'h2, 32'd100, 32'd7, 5'd2, 32'd14, 1'b0, 33);
        add(4'h3, 32'd100, 32'd7, 5'd3, 32'd2, 1'b0, 33);
        add(4'h2, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0, 1);
        add(4'h3, 32'd5, 32'd0, 5'd5, 32'd5, 1'b0, 1);
        add(4'h0, 32'hFFFF_FFFF, 32'd2, 5'd6, 32'hFFFF_FFFE, 1'b0, 33);
        add(4'h0, 32'd9, 32'd0, 5'd8, 32'd0, 1'b0, 33);
        add(4'h2, 32'd7, 32'd100, 5'd9, 32'd0, 1'b0, 33);
        add(4'h7, 32'd1, 32'd1, 5'd10, 32'd0, 1'b1, 1);
        add(4'hF, 32'd1, 32'd1, 5'd31, 32'd0, 1'b1, 1);
        add(4'h5, 32'hFFFF_FFF9, 32'd2, 5'd11, SGN ? 32'hFFFF_FFFD : 32'd0, !SGN, SGN ? 33 : 1);
        add(4'h6, 32'hFFFF_FFF9, 32'd2, 5'd12, SGN ? 32'hFFFF_FFFF : 32'd0, !SGN, SGN ? 33 : 1);
        add(4'h5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, SGN ? 32'h8000_0000 : 32'd0, !SGN, SGN ? 33 : 1);
        add(4'h6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, !SGN, SGN ? 33 : 1);
        add(4'h5, 32'hFFFF_FFF9, 32'd0, 5'd15, SGN ? 32'hFFFF_FFFF : 32'd0, !SGN, 1);
        add(4'h6, 32'hFFFF_FFF9, 32'd0, 5'd16, SGN ? 32'hFFFF_FFF9 : 32'd0, !SGN, 1);
        add(4'h4, 32'hFFFF_FFFE, 32'd3, 5'd17, SGN ? 32'hFFFF_FFFF : 32'd0, !SGN, SGN ? 33 : 1);

        #12 @(negedge clk); rst_n = 1'b1;
        #1;
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        chk("reset rsp_tag", bus.rsp_tag, 0);
        chk("reset rsp_err", bus.rsp_err, 0);
        chk("reset req_ready", bus.req_ready, 1);

        for (int i = 0; i < nvec; i++) begin
            run_op(vecs[i].opt, vecs[i].a, vecs[i].b, vecs[i].tag, d, t, e, lat);
            chk($sformatf("vec%0d data", i), d, vecs[i].exp_d);
            chk($sformatf("vec%0d tag", i), t, vecs[i].tag);
            chk($sformatf("vec%0d err", i), e, vecs[i].exp_e);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure: response held stable, then back-to-back accept.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opt = 4'h0; bus.req_a = 32'd1000; bus.req_b = 32'd1001; bus.req_tag = 5'd21;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("hold latency", lat, 33);
        held_d = bus.rsp_data; held_t = bus.rsp_tag;
        chk("hold data", held_d, 32'd1001000);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("hold rsp_valid", bus.rsp_valid, 1);
            chk("hold rsp_data", bus.rsp_data, held_d);
            chk("hold rsp_tag", bus.rsp_tag, held_t);
            chk("hold req_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_opt = 4'h2; bus.req_a = 32'd100; bus.req_b = 32'd7; bus.req_tag = 5'd22;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;
        chk("post-handshake rsp_valid", bus.rsp_valid, 0);
        chk("post-handshake req_ready", bus.req_ready, 1);
        @(posedge clk); #1; bus.req_valid = 1'b0;
        chk("b2b accepted", bus.req_ready, 0);
        lat = 1;
        while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("b2b latency", lat, 33);
        chk("b2b data", bus.rsp_data, 32'd14);
        chk("b2b tag", bus.rsp_tag, 5'd22);
        @(negedge clk); bus.rsp_ready = 1'b1;
        @(posedge clk); #1; bus.rsp_ready = 1'b0;

        // Flush at BUSY step 10.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opt = 4'h0; bus.req_a = 32'd7; bus.req_b = 32'd9; bus.req_tag = 5'd23;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        chk("flush rsp_valid", bus.rsp_valid, 0);
        chk("flush req_ready low", bus.req_ready, 0);
        flush = 1'b0; #1;
        chk("flush idle ready", bus.req_ready, 1);
        watch_quiet("flush no response", 40);
        run_op(4'h0, 32'd3, 32'd4, 5'd24, d, t, e, lat);
        chk("post-flush data", d, 32'd12);
        chk("post-flush latency", lat, 33);

        // Request presented during flush is ignored.
        @(negedge clk);
        flush = 1'b1; bus.req_valid = 1'b1; bus.req_opt = 4'h2; bus.req_b = 32'd0;
        @(posedge clk); #1; flush = 1'b0; bus.req_valid = 1'b0;
        watch_quiet("flush-cycle request dropped", 40);

        // Flush while a response is pending drops it.
        run_op(4'h7, 32'd0, 32'd0, 5'd1, d, t, e, lat);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opt = 4'hE; bus.req_tag = 5'd2;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        chk("done before flush", bus.rsp_valid, 1);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        watch_quiet("done flushed", 5);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_opt = 4'h1; bus.req_a = 32'hDEAD_BEEF; bus.req_b = 32'h1234_5678; bus.req_tag = 5'd25;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset rsp_valid", bus.rsp_valid, 0);
        chk("async reset req_ready", bus.req_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        watch_quiet("no response after reset", 40);

        // Random operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 8);
            op = ops[r];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 15);
                default: ;
            endcase
            tg = 5'($urandom);
            model(op, ra, rb, ed, ee, el);
            run_op(op, ra, rb, tg, d, t, e, lat);
            chk($sformatf("rnd%0d op%0h %0h,%0h data", i, op, ra, rb), d, ed);
            chk($sformatf("rnd%0d tag", i), t, tg);
            chk($sformatf("rnd%0d err", i), e, ee);
            chk($sformatf("rnd%0d latency", i), lat, el);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the CPU execute stage, parametrised in data width. It adds the MUL/DIV/REM class that the single-cycle ALU does not provide, using one shift-add or shift-subtract step per clock. Operands and a writeback tag enter through a valid/ready request port, and the result leaves through a valid/ready response port. A flush input lets interrupt entry abandon an in-flight operation.

## Interface
- `XLEN`, default 32: operand/result width, ≥ 4, power of two.
- `TAG_W`, default 5: width of the opaque tag (destination register index) carried request→response.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous abort; returns the unit to IDLE.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_opt` in 4: operation select (see Operation).
- `req_a` in XLEN: dividend or multiplicand.
- `req_b` in XLEN: divisor or multiplier.
- `req_tag` in TAG_W: tag returned unchanged.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_data` out XLEN: result.
- `rsp_tag` out TAG_W: tag of the request.
- `rsp_err` out 1: unsupported `req_opt`; `rsp_data` = 0.

## Operation
- Opcodes:
  - 4'h0 MUL: low XLEN bits of a×b.
  - 4'h1 MULHU: high XLEN bits of unsigned a×b.
  - 4'h2 DIVU: unsigned quotient.
  - 4'h3 REMU: unsigned remainder.
  - 4'h4 MULH, 4'h5 DIV, 4'h6 REM: signed variants, available only with the macro.
  - Any other opt is unsupported.
- States:
  - IDLE: `req_ready` = !flush. On handshake, capture operands, tag and opt.
    - Unsupported opt or divisor = 0 → DONE.
    - Otherwise → BUSY with the step counter at 0.
  - BUSY: one radix-2 step per cycle. After step XLEN−1 → DONE.
  - DONE: `rsp_valid` = 1. On `rsp_ready` → IDLE. Response outputs are held stable while waiting.
- Multiply: 2·XLEN-bit product register, shift-add, LSB of multiplier first.
- Divide: restoring shift-subtract on a {remainder, quotient} register of 2·XLEN bits.
- Divide by zero: quotient = all ones, remainder = a. `rsp_err` = 0.
- Signed operations (macro on):
  - Take magnitudes at capture; negate the result at DONE entry.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Overflow (a = −2^(XLEN−1), b = −1): DIV returns a, REM returns 0.
  - Signed divide by zero: DIV → all ones, REM → a.
- Flush:
  - Any state → IDLE on the next edge.
  - Any pending `rsp_valid` is dropped with no response.
  - A request presented in the flush cycle is not accepted.
- All arithmetic is modulo 2^XLEN except the internal 2·XLEN product/remainder registers.

## Timing
- Reset values:
  - State IDLE; `rsp_valid` = 0; `rsp_data` = 0; `rsp_tag` = 0; `rsp_err` = 0.
  - `req_ready` = 1 after reset deasserts (while flush is low).
- Latency, counted from the accept edge to the first cycle with `rsp_valid` high:
  - XLEN+1 cycles for normal operations (33 for XLEN = 32).
  - 1 cycle for divide-by-zero and unsupported opt.
- Throughput: one operation in flight. `req_ready` is 0 in BUSY and DONE, so the next accept is possible no earlier than the cycle after the response handshake.
- Reset asserted mid-operation clears everything immediately, asynchronously. No response is produced.
- `rsp_valid` never drops without `rsp_ready` or `flush`.

## Configuration
- `MDU_SIGNED_EN`
  - Defined: opts 4'h4–4'h6 are implemented as signed operations.
  - Undefined: those opts are unsupported (latency 1, `rsp_err` = 1, `rsp_data` = 0). The sign-correction logic is not compiled.

## Test plan
- MUL a=32'd12345, b=32'd6789, tag=5'd7 → `rsp_data` = 32'd83810205, `rsp_tag` = 7, `rsp_valid` first high 33 cycles after accept.
- MULHU a=b=32'hFFFF_FFFF → 32'hFFFF_FFFE. DIVU 32'd100 / 32'd7 → 32'd14; REMU → 32'd2.
- DIVU 32'd5 / 32'd0 → 32'hFFFF_FFFF after 1 cycle; REMU 32'd5 / 32'd0 → 32'd5.
- With `MDU_SIGNED_EN`:
  - DIV −7/2 → −3 (32'hFFFF_FFFD); REM → −1.
  - DIV 32'h8000_0000 / −1 → 32'h8000_0000.
  - Without the macro, opt 4'h5 → `rsp_err` = 1, `rsp_data` = 0.
- Hold `rsp_ready` low 10 cycles after `rsp_valid` → `rsp_data`/`rsp_tag` stable and `req_ready` = 0 throughout. A new request is accepted in the cycle after the handshake.
- Assert `flush` at BUSY step 10 → IDLE next cycle, no response, `req_ready` = 1. A following MUL 3×4 returns 12 normally.
